// File: rtl/pic_host_bus_master.sv
`timescale 1ns/1ps
// CPU-side 8259 bus master: ICW init sequences, single writes/reads and the two-pulse INTA fetch.
// One bus cycle at a time; commands are accepted only while cmd_ready is high (never queued).
module pic_host_bus_master #(
  parameter int SETUP   = 1,
  parameter int PULSE_W = 2,
  parameter int RECOVER = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       init_done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       INT,
  input  logic       int_ack_en,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       WD,
  output logic       RD,
  output logic       INTA,
  output logic       A0,
  inout  wire  [7:0] data_bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOV} state_t;
  typedef enum logic [1:0] {K_WR, K_RD, K_INTA1, K_INTA2} kind_t;

  localparam logic [7:0] C_SETUP = 8'(SETUP - 1);
  localparam logic [7:0] C_PW    = 8'(PULSE_W - 1);
  localparam logic [7:0] C_REC   = 8'(RECOVER - 1);

  state_t     state;
  kind_t      kind;
  logic [7:0] cnt;
  logic [7:0] dout;
  logic       data_oe;
  logic       init_active;
  logic [1:0] init_idx;
  logic       last_word;
  logic       need3;
  logic       need4;
  logic [7:0] w2, w3, w4;
  logic [7:0] init_word;
  logic [2:0] init_next;
  logic       int_req;

  assign int_req   = INT && int_ack_en;
  assign cmd_ready = (state == S_IDLE) && !init_active && !int_req;
  assign data_bus  = data_oe ? dout : 8'hzz;

  // init_idx names the next ICW still owed (1=ICW2, 2=ICW3, 3=ICW4); ICW1 goes out on init_start.
  always_comb begin
    init_word = w4;
    init_next = 3'b000;
    case (init_idx)
      2'd1: begin
        init_word = w2;
        init_next = need3 ? 3'b110 : (need4 ? 3'b111 : 3'b000);
      end
      2'd2: begin
        init_word = w3;
        init_next = need4 ? 3'b111 : 3'b000;
      end
      default: begin
        init_word = w4;
        init_next = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      kind         <= K_WR;
      cnt          <= 8'd0;
      dout         <= 8'd0;
      data_oe      <= 1'b0;
      init_active  <= 1'b0;
      init_idx     <= 2'd0;
      last_word    <= 1'b0;
      need3        <= 1'b0;
      need4        <= 1'b0;
      w2           <= 8'd0;
      w3           <= 8'd0;
      w4           <= 8'd0;
      WD           <= 1'b1;
      RD           <= 1'b1;
      INTA         <= 1'b1;
      A0           <= 1'b0;
      rd_data      <= 8'd0;
      rd_valid     <= 1'b0;
      vector       <= 8'd0;
      vector_valid <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      rd_valid     <= 1'b0;
      vector_valid <= 1'b0;
      init_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (int_req) begin
            kind  <= K_INTA1;
            A0    <= 1'b0;
            INTA  <= 1'b0;
            cnt   <= C_PW;
            state <= S_STROBE;
          end else if (init_active) begin
            kind        <= K_WR;
            A0          <= 1'b1;
            dout        <= init_word;
            data_oe     <= 1'b1;
            init_active <= init_next[2];
            init_idx    <= init_next[1:0];
            last_word   <= !init_next[2];
            cnt         <= C_SETUP;
            state       <= S_SETUP;
          end else if (init_start) begin
            kind        <= K_WR;
            A0          <= 1'b0;
            dout        <= icw1;
            data_oe     <= 1'b1;
            w2          <= icw2;
            w3          <= icw3;
            w4          <= icw4;
            need3       <= !icw1[1];
            need4       <= icw1[0];
            init_active <= 1'b1;
            init_idx    <= 2'd1;
            last_word   <= 1'b0;
            cnt         <= C_SETUP;
            state       <= S_SETUP;
          end else if (cmd_valid) begin
            kind      <= cmd_rd ? K_RD : K_WR;
            A0        <= cmd_a0;
            dout      <= cmd_data;
            data_oe   <= !cmd_rd;
            last_word <= 1'b0;
            cnt       <= C_SETUP;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == 8'd0) begin
            WD    <= (kind != K_WR);
            RD    <= (kind != K_RD);
            cnt   <= C_PW;
            state <= S_STROBE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_STROBE: begin
          if (cnt == 8'd0) begin
            WD    <= 1'b1;
            RD    <= 1'b1;
            INTA  <= 1'b1;
            cnt   <= C_REC;
            state <= S_RECOV;
            if (kind == K_RD) begin
              rd_data  <= data_bus;
              rd_valid <= 1'b1;
            end
            if (kind == K_INTA2) begin
              vector       <= data_bus;
              vector_valid <= 1'b1;
            end
            if (kind == K_WR && last_word) begin
              init_done <= 1'b1;
              last_word <= 1'b0;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          if (cnt == 8'd0) begin
            if (kind == K_INTA1) begin
              // Second acknowledge follows the first directly; nothing may slip in between.
              kind  <= K_INTA2;
              INTA  <= 1'b0;
              cnt   <= C_PW;
              state <= S_STROBE;
            end else begin
              data_oe <= 1'b0;
              state   <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_bus_master.sv
`timescale 1ns/1ps
// Directed bench for pic_host_bus_master: writes, reads, ICW sequences, INTA, preemption and reset.
module tb_pic_host_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid, cmd_rd, cmd_a0, init_start, INT, int_ack_en;
  logic [7:0] cmd_data, icw1, icw2, icw3, icw4, inta_val;
  logic       cmd_ready, init_done, rd_valid, vector_valid, WD, RD, INTA, A0;
  logic [7:0] rd_data, vector;
  wire  [7:0] data_bus;

  // Bench acts as the PIC: answers reads with 0x60 and INTA pulses with inta_val.
  assign data_bus = (!RD) ? 8'h60 : ((!INTA) ? inta_val : 8'hzz);

  pic_host_bus_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_a0(cmd_a0), .cmd_data(cmd_data), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .init_done(init_done),
    .rd_data(rd_data), .rd_valid(rd_valid), .INT(INT), .int_ack_en(int_ack_en),
    .vector(vector), .vector_valid(vector_valid), .WD(WD), .RD(RD), .INTA(INTA),
    .A0(A0), .data_bus(data_bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rdv_cnt = 0;
  int vv_cnt = 0;
  int excl_err = 0;

  always @(negedge clk) begin
    if (init_done) done_cnt++;
    if (rd_valid) rdv_cnt++;
    if (vector_valid) vv_cnt++;
    if ((32'(!WD) + 32'(!RD) + 32'(!INTA)) > 1) excl_err++;
  end

  int         hi, len;
  logic [7:0] dat;
  logic       a0v;
  bit         to;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic strobe(input int s);
    case (s)
      0:       strobe = WD;
      1:       strobe = RD;
      default: strobe = INTA;
    endcase
  endfunction

  // Waits (bounded) for the selected strobe to fall, then measures the low pulse.
  // Returns in the first high cycle after the pulse; dat/a0v hold the last low-cycle values.
  task automatic wait_low(input int s, input bit raise_int, input int bound);
    hi = 0; len = 0; to = 0; dat = 8'h00; a0v = 1'b0;
    while (strobe(s) !== 1'b0 && hi < bound) begin
      step();
      hi++;
    end
    if (strobe(s) !== 1'b0) begin
      to = 1;
      return;
    end
    if (raise_int) INT = 1'b1;
    while (strobe(s) === 1'b0 && len < 60) begin
      dat = data_bus;
      a0v = A0;
      len++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
    init_start = 1'b0; INT = 1'b0; int_ack_en = 1'b0; inta_val = 8'h00;
    icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00;
    repeat (3) step();
    checks++; if ({WD, RD, INTA, A0} !== 4'b1110) begin errors++; $display("FAIL rst_strobes got %b exp 1110", {WD, RD, INTA, A0}); end
    checks++; if ({rd_data, vector} !== 16'h0000) begin errors++; $display("FAIL rst_data got %h exp 0000", {rd_data, vector}); end
    checks++; if ({rd_valid, init_done, vector_valid} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {rd_valid, init_done, vector_valid}); end
    checks++; if (dut.data_oe !== 1'b0) begin errors++; $display("FAIL rst_bus_oe got %b exp 0", dut.data_oe); end
    rst_n = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'hAA;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready0 got %b exp 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (WD !== ((k == 2 || k == 3) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL wr_wd k=%0d got %b", k, WD); end
      checks++; if (cmd_ready !== (k == 5)) begin errors++; $display("FAIL wr_ready k=%0d got %b exp %b", k, cmd_ready, k == 5); end
      if (k <= 4) begin
        checks++; if (A0 !== 1'b1) begin errors++; $display("FAIL wr_a0 k=%0d got %b exp 1", k, A0); end
        checks++; if (data_bus !== 8'hAA) begin errors++; $display("FAIL wr_data k=%0d got %h exp aa", k, data_bus); end
      end
      step();
    end
  endtask

  task automatic test_read();
    rdv_cnt = 0;
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h55;
    step();
    cmd_valid = 1'b0;
    checks++; if (dut.data_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_setup got %b exp 0", dut.data_oe); end
    wait_low(1, 1'b0, 10);
    checks++; if (to || len != 2) begin errors++; $display("FAIL rd_pulse got len %0d timeout %0d exp len 2", len, to); end
    checks++; if (a0v !== 1'b0) begin errors++; $display("FAIL rd_a0 got %b exp 0", a0v); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h60) begin errors++; $display("FAIL rd_result got v=%b d=%h exp v=1 d=60", rd_valid, rd_data); end
    checks++; if (dut.data_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_recov got %b exp 0", dut.data_oe); end
    step();
    step();
    checks++; if (rdv_cnt != 1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got count %0d exp 1", rdv_cnt); end
  endtask

  task automatic test_init();
    logic [7:0] exp_d [4];
    logic       exp_a [4];
    exp_d[0] = 8'h15; exp_d[1] = 8'h20; exp_d[2] = 8'h00; exp_d[3] = 8'h1F;
    exp_a[0] = 1'b0;  exp_a[1] = 1'b1;  exp_a[2] = 1'b1;  exp_a[3] = 1'b1;
    for (int run = 0; run < 2; run++) begin
      done_cnt = 0;
      icw1 = (run == 0) ? 8'h15 : 8'h12; icw2 = 8'h20; icw3 = 8'h00; icw4 = 8'h1F;
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      icw1 = 8'hFF; icw2 = 8'hFF; icw3 = 8'hFF; icw4 = 8'hFF;
      for (int i = 0; i < ((run == 0) ? 4 : 2); i++) begin
        wait_low(0, 1'b0, 20);
        checks++; if (to || len != 2) begin errors++; $display("FAIL init%0d_pulse%0d got len %0d timeout %0d exp len 2", run, i, len, to); end
        checks++; if (dat !== ((run == 1 && i == 0) ? 8'h12 : exp_d[i]) || a0v !== exp_a[i]) begin
          errors++; $display("FAIL init%0d_word%0d got %h a0=%b exp %h a0=%b", run, i, dat, a0v, (run == 1 && i == 0) ? 8'h12 : exp_d[i], exp_a[i]);
        end
      end
      wait_low(0, 1'b0, 8);
      checks++; if (!to) begin errors++; $display("FAIL init%0d_extra got an extra WD pulse data %h exp none", run, dat); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL init%0d_done got %0d pulses exp 1", run, done_cnt); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL init%0d_ready got %b exp 1", run, cmd_ready); end
    end
  endtask

  task automatic test_inta();
    vv_cnt = 0;
    INT = 1'b1; int_ack_en = 1'b1; inta_val = 8'h99;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL inta_ready_req got %b exp 0", cmd_ready); end
    wait_low(2, 1'b0, 10);
    checks++; if (to || len != 2 || a0v !== 1'b0) begin errors++; $display("FAIL inta_p1 got len %0d a0 %b timeout %0d exp len 2 a0 0", len, a0v, to); end
    INT = 1'b0; inta_val = 8'h27;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL inta_ready_mid got %b exp 0", cmd_ready); end
    wait_low(2, 1'b0, 10);
    checks++; if (to || hi != 1 || len != 2) begin errors++; $display("FAIL inta_p2 got gap %0d len %0d timeout %0d exp gap 1 len 2", hi, len, to); end
    checks++; if (vector_valid !== 1'b1 || vector !== 8'h27) begin errors++; $display("FAIL inta_vector got v=%b d=%h exp v=1 d=27", vector_valid, vector); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL inta_ready_recov got %b exp 0", cmd_ready); end
    step();
    checks++; if (cmd_ready !== 1'b1 || vector_valid !== 1'b0 || vv_cnt != 1) begin
      errors++; $display("FAIL inta_end got ready %b vv %b count %0d exp 1 0 1", cmd_ready, vector_valid, vv_cnt);
    end
  endtask

  task automatic test_preempt();
    done_cnt = 0; vv_cnt = 0; inta_val = 8'h33;
    icw1 = 8'h15; icw2 = 8'h20; icw3 = 8'h00; icw4 = 8'h1F;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    wait_low(0, 1'b0, 20);
    checks++; if (to || dat !== 8'h15) begin errors++; $display("FAIL pre_icw1 got %h timeout %0d exp 15", dat, to); end
    wait_low(0, 1'b1, 20);
    checks++; if (to || len != 2 || dat !== 8'h20) begin errors++; $display("FAIL pre_icw2 got %h len %0d exp 20 len 2", dat, len); end
    wait_low(2, 1'b0, 20);
    checks++; if (to || len != 2) begin errors++; $display("FAIL pre_inta1 got len %0d timeout %0d exp 2", len, to); end
    INT = 1'b0;
    wait_low(2, 1'b0, 20);
    checks++; if (to || vector !== 8'h33 || vector_valid !== 1'b1) begin errors++; $display("FAIL pre_vector got %h v=%b exp 33 v=1", vector, vector_valid); end
    wait_low(0, 1'b0, 20);
    checks++; if (to || dat !== 8'h00 || a0v !== 1'b1) begin errors++; $display("FAIL pre_icw3 got %h a0=%b exp 00 a0=1", dat, a0v); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL pre_early_done got %0d exp 0", done_cnt); end
    wait_low(0, 1'b0, 20);
    checks++; if (to || dat !== 8'h1F) begin errors++; $display("FAIL pre_icw4 got %h exp 1f", dat); end
    repeat (3) step();
    checks++; if (done_cnt != 1 || vv_cnt != 1) begin errors++; $display("FAIL pre_counts got done %0d vv %0d exp 1 1", done_cnt, vv_cnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    done_cnt = 0; rdv_cnt = 0;
    icw1 = 8'h12; icw2 = 8'h20; icw3 = 8'h00; icw4 = 8'h1F;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    wait_low(0, 1'b0, 20);
    n = 0;
    while (WD !== 1'b0 && n < 20) begin step(); n++; end
    step();
    checks++; if (WD !== 1'b0) begin errors++; $display("FAIL rm_second_low got %b exp 0", WD); end
    rst_n = 1'b0;
    step();
    checks++; if (WD !== 1'b1 || dut.data_oe !== 1'b0) begin errors++; $display("FAIL rm_bus got WD %b oe %b exp 1 0", WD, dut.data_oe); end
    checks++; if (cmd_ready !== 1'b1 || init_done !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL rm_state got ready %b done %b rdv %b exp 1 0 0", cmd_ready, init_done, rd_valid);
    end
    rst_n = 1'b1;
    wait_low(0, 1'b0, 10);
    checks++; if (!to || done_cnt != 0 || rdv_cnt != 0) begin errors++; $display("FAIL rm_after got pulse %0d done %0d rdv %0d exp none 0 0", !to, done_cnt, rdv_cnt); end
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h5A;
    step();
    cmd_valid = 1'b0;
    wait_low(0, 1'b0, 10);
    checks++; if (to || dat !== 8'h5A || a0v !== 1'b0) begin errors++; $display("FAIL rm_recover got %h a0=%b exp 5a a0=0", dat, a0v); end
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_init();
    test_inta();
    test_preempt();
    test_reset_mid();
    checks++; if (excl_err != 0) begin errors++; $display("FAIL strobe_exclusive got %0d overlap cycles exp 0", excl_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pic_host_bus_master.md
Name: pic_host_bus_master

Overview:
- Synchronous CPU-side bus master that generates every 8259 host bus cycle toward control_logic:
  - ICW initialization sequences
  - single OCW/ICW writes
  - status reads (IRR/ISR/poll)
  - the two-pulse INTA acknowledge that fetches the interrupt vector.
- Drives the active-low strobes WD/RD/INTA, the A0 address line and the shared data_bus.
- Hands results back to a simple valid/ready command interface.

Parameters:
- SETUP, 1, cycles A0/data are stable before a strobe falls (min 1)
- PULSE_W, 2, cycles a strobe (WD/RD/INTA) is held low (min 1)
- RECOVER, 1, cycles with all strobes high after each strobe (min 1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  single-cycle command request
- cmd_ready  output  1  master idle and able to accept a command
- cmd_rd  input  1  0 = write cycle, 1 = read cycle
- cmd_a0  input  1  A0 value for the command
- cmd_data  input  8  write data
- init_start  input  1  start ICW sequence (sampled only when cmd_ready=1)
- icw1, icw2, icw3, icw4  input  8 each  init words, captured on init_start
- init_done  output  1  one-cycle pulse after the last ICW write
- rd_data  output  8  data sampled during a read
- rd_valid  output  1  one-cycle pulse, rd_data valid
- INT  input  1  interrupt request from the PIC
- int_ack_en  input  1  enables automatic INTA servicing
- vector  output  8  vector captured on the 2nd INTA pulse
- vector_valid  output  1  one-cycle pulse, vector valid
- WD  output  1  active-low write strobe
- RD  output  1  active-low read strobe
- INTA  output  1  active-low interrupt acknowledge
- A0  output  1  address line
- data_bus  inout  8  driven only by this block while data_oe is internally set, otherwise high-Z

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the next state to:
  - WD=RD=INTA=1, A0=0, data_bus=Z
  - rd_data=0, vector=0, rd_valid=init_done=vector_valid=0
  - FSM=IDLE, init queue cleared
- Reset wins over every other event, including mid-cycle; the strobe rises on the reset edge.
- FSM states: IDLE, SETUP, STROBE, RECOV. A kind register selects WR, RD or INTA1/INTA2. A phase counter counts SETUP, PULSE_W and RECOVER cycles.
- Arbitration in IDLE, highest priority first:
  1. INT&&int_ack_en → INTA sequence
  2. pending init word
  3. init_start
  4. cmd_valid
- cmd_ready = (state==IDLE) && !init_active && !(INT&&int_ack_en). It is combinational.
- Write cycle, accepted at edge T:
  - T+1 .. T+SETUP: A0 and data_bus driven
  - next PULSE_W cycles: WD=0
  - RECOV: WD=1, data held 1 cycle, then released
  - Return to IDLE after RECOVER cycles.
  - Total with defaults: 4 cycles, ready again at T+5.
- Read cycle:
  - Same timing with RD in place of WD; data_bus stays Z throughout.
  - data_bus is sampled on the last low cycle of RD.
  - rd_valid pulses in the first RECOV cycle.
- Init sequence, on init_start: latch icw1..icw4, then issue these writes back-to-back, each a full write cycle:
  - ICW1 with A0=0
  - ICW2 with A0=1
  - ICW3 with A0=1, only if icw1[1]==0 (cascade)
  - ICW4 with A0=1, only if icw1[0]==1 (IC4)
  - init_done pulses in the RECOV cycle of the final write.
- INTA sequence:
  - A0 is not driven (held 0) and data_bus=Z.
  - INTA1: INTA low PULSE_W, then RECOVER cycles high.
  - INTA2: INTA low PULSE_W; vector sampled on its last low cycle; vector_valid pulses in the next cycle.
  - Return to IDLE.
  - INT falling mid-sequence does not abort the sequence.
- Preemption: an INTA request arriving while an init sequence is pending is serviced between ICW writes, never inside a bus cycle. The init sequence then resumes with the next ICW.
- Strobes are mutually exclusive. At most one of WD/RD/INTA is low in any cycle.
- cmd_valid while cmd_ready=0 is ignored; it is not queued.

Test Plan:
1. Reset release, then a write with cmd_a0=1, cmd_data=0xAA → WD low exactly 2 cycles starting 2 cycles after accept; A0=1 and data_bus=0xAA from accept+1 through accept+4; cmd_ready high again at accept+5.
2. init_start with icw1=0x15, icw2=0x20, icw3=0x00, icw4=0x1F → four WD pulses carrying 0x15(A0=0), 0x20, 0x00, 0x1F (A0=1); init_done single pulse. Repeat with icw1=0x12 → two writes only (0x12, 0x20).
3. Read with cmd_a0=0 while bench drives data_bus=0x60 during RD low → rd_valid one pulse, rd_data=0x60, data_bus never driven by the DUT.
4. INT=1, int_ack_en=1, bench drives 0x27 during the second INTA pulse → two INTA pulses of 2 cycles separated by 1 high cycle; vector=0x27, vector_valid one pulse; cmd_ready=0 until the sequence finishes.
5. INT asserted during ICW2 of an init → ICW2 completes, INTA sequence runs, then ICW3/ICW4 complete; init_done fires after ICW4.
6. rst_n=0 in the second WD-low cycle → next cycle WD=1, data_bus=Z, FSM=IDLE; no init_done, no rd_valid.
